// File: rtl/keccak_padder_multi.sv
// Absorb-side multi-rate padder: packs 64-bit little-endian message words into
// rate-sized blocks and applies FIPS 202 padding for SHAKE128/256 and SHA3-256/512.
module keccak_padder_multi #(
    parameter int          LANE_W    = 64,
    parameter int          MAX_LANES = 21,
    parameter logic [7:0]  DS_SHAKE  = 8'h1F,
    parameter logic [7:0]  DS_SHA3   = 8'h06
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    mode,
    input  logic [LANE_W-1:0]             in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [3:0]                    in_nbytes,
    output logic                          in_ready,
    output logic [LANE_W*MAX_LANES-1:0]   out_block,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [4:0]                    out_lanes,
    input  logic                          out_ready
);

    typedef enum logic [1:0] {ABSORB, PAD, OUT} state_t;

    function automatic logic [4:0] rate_of(input logic [1:0] m);
        case (m)
            2'd0:    rate_of = 5'd21;
            2'd1:    rate_of = 5'd17;
            2'd2:    rate_of = 5'd17;
            default: rate_of = 5'd9;
        endcase
    endfunction

    state_t                        state;
    logic [LANE_W*MAX_LANES-1:0]   buf_q;
    logic [4:0]                    cnt;
    logic                          msg_active;
    logic                          pad_pending;
    logic                          last_blk;
    logic [1:0]                    mode_q;
    logic                          in_ready_q;
    logic                          out_valid_q;

    logic [1:0]        eff_mode;
    logic [4:0]        last_idx;
    logic [7:0]        ds;
    logic              at_end;
    logic              full_word;
    logic [10:0]       lane_off;
    logic [10:0]       end_off;
    logic [LANE_W-1:0] tail_word;

    // The first word of a message is padded with the incoming mode, later ones with the latched one.
    assign eff_mode  = msg_active ? mode_q : mode;
    assign last_idx  = rate_of(eff_mode) - 5'd1;
    assign ds        = eff_mode[1] ? DS_SHA3 : DS_SHAKE;
    assign at_end    = (cnt == last_idx);
    assign full_word = in_nbytes[3];
    assign lane_off  = {cnt, 6'b0};
    assign end_off   = {last_idx, 6'b0} + 11'd56;

    always_comb begin
        tail_word = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (4'(k) < in_nbytes)
                tail_word[8*k +: 8] = in_data[8*k +: 8];
            else if (4'(k) == in_nbytes)
                tail_word[8*k +: 8] = ds;
        end
        if (at_end)
            tail_word[63:56] = tail_word[63:56] | 8'h80;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ABSORB;
            buf_q       <= '0;
            cnt         <= '0;
            msg_active  <= 1'b0;
            pad_pending <= 1'b0;
            last_blk    <= 1'b0;
            mode_q      <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ABSORB: begin
                    if (in_valid) begin
                        if (!msg_active) begin
                            mode_q     <= mode;
                            msg_active <= 1'b1;
                        end
                        if (!in_last || full_word)
                            buf_q[lane_off +: LANE_W] <= in_data;
                        else
                            buf_q[lane_off +: LANE_W] <= tail_word;
                        if (in_last && full_word)
                            pad_pending <= 1'b1;
                        if (at_end) begin
                            last_blk    <= in_last && !full_word;
                            state       <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                            if (in_last) begin
                                state      <= PAD;
                                in_ready_q <= 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (pad_pending)
                        buf_q[lane_off +: 8] <= buf_q[lane_off +: 8] | ds;
                    buf_q[end_off +: 8] <= buf_q[end_off +: 8] | 8'h80;
                    pad_pending <= 1'b0;
                    last_blk    <= 1'b1;
                    state       <= OUT;
                    out_valid_q <= 1'b1;
                end
                default: begin
                    if (out_ready) begin
                        buf_q       <= '0;
                        cnt         <= '0;
                        out_valid_q <= 1'b0;
                        if (pad_pending) begin
                            state <= PAD;
                        end else begin
                            if (last_blk)
                                msg_active <= 1'b0;
                            last_blk   <= 1'b0;
                            state      <= ABSORB;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = last_blk;
    assign out_block = buf_q;
    assign out_lanes = rate_of(mode_q);

endmodule

// File: tb/tb_keccak_padder_multi.sv
// Directed bench for keccak_padder_multi: hand-computed padded blocks for each
// mode, pad-only trailing block, backpressure, mid-message mode change, async reset.
module tb_keccak_padder_multi;

    localparam int LW = 64;
    localparam int ML = 21;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [1:0]         mode;
    logic [LW-1:0]      in_data;
    logic               in_valid;
    logic               in_last;
    logic [3:0]         in_nbytes;
    logic               in_ready;
    logic [LW*ML-1:0]   out_block;
    logic               out_valid;
    logic               out_last;
    logic [4:0]         out_lanes;
    logic               out_ready;

    always #5 clk = ~clk;

    keccak_padder_multi #(.LANE_W(LW), .MAX_LANES(ML), .DS_SHAKE(8'h1F), .DS_SHA3(8'h06)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_nbytes(in_nbytes),
        .in_ready(in_ready), .out_block(out_block), .out_valid(out_valid),
        .out_last(out_last), .out_lanes(out_lanes), .out_ready(out_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [LW*ML-1:0] exp_blk;
    logic [LW*ML-1:0] cap_blk;
    logic             cap_last;
    logic [4:0]       cap_lanes;
    int               cap_wait;

    localparam logic [63:0] TOP80 = 64'h8000_0000_0000_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send(input logic [63:0] d, input logic l, input logic [3:0] nb);
        int k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        in_data = d; in_last = l; in_nbytes = nb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_nbytes = 4'd0;
    endtask

    // Waits for out_valid, captures the block, optionally stalls, then consumes it.
    task automatic get_block(input int hold);
        cap_wait = 0;
        while (!out_valid && cap_wait < 200) begin
            @(posedge clk); #1; cap_wait++;
        end
        check("out_valid", 64'(out_valid), 64'd1);
        cap_blk = out_block; cap_last = out_last; cap_lanes = out_lanes;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_stable", 64'(out_block === cap_blk && out_last === cap_last && out_lanes === cap_lanes), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_blk(input string tag);
        for (int j = 0; j < ML; j++)
            check($sformatf("%s_lane%0d", tag, j), cap_blk[64*j +: 64], exp_blk[64*j +: 64]);
    endtask

    initial begin
        reset_n = 1'b0; mode = 2'd0; in_data = '0; in_valid = 1'b0;
        in_last = 1'b0; in_nbytes = 4'd0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_lanes", 64'(out_lanes), 64'd21);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_block_zero", 64'(out_block === '0), 64'd1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // SHAKE128 empty message
        mode = 2'd0;
        send(64'd0, 1'b1, 4'd0);
        get_block(0);
        check("empty_latency", 64'(cap_wait), 64'd1);
        exp_blk = '0; exp_blk[0 +: 64] = 64'h1F; exp_blk[64*20 +: 64] = TOP80;
        check_blk("empty");
        check("empty_last", 64'(cap_last), 64'd1);
        check("empty_lanes", 64'(cap_lanes), 64'd21);

        // SHA3-512, 9 full words -> data block then pad-only block
        mode = 2'd3;
        for (int i = 1; i <= 9; i++)
            send(64'(i), (i == 9), (i == 9) ? 4'd8 : 4'd0);
        get_block(0);
        check("s512a_latency", 64'(cap_wait), 64'd0);
        exp_blk = '0;
        for (int i = 0; i < 9; i++) exp_blk[64*i +: 64] = 64'(i + 1);
        check_blk("s512a");
        check("s512a_last", 64'(cap_last), 64'd0);
        check("s512a_lanes", 64'(cap_lanes), 64'd9);
        get_block(0);
        exp_blk = '0; exp_blk[0 +: 64] = 64'h06; exp_blk[64*8 +: 64] = TOP80;
        check_blk("s512b");
        check("s512b_last", 64'(cap_last), 64'd1);

        // SHAKE256, DS and 0x80 share the top byte of the final lane
        mode = 2'd1;
        for (int i = 0; i < 16; i++) send(64'h100 + 64'(i), 1'b0, 4'd0);
        send(64'h1122_3344_5566_7788, 1'b1, 4'd7);
        get_block(0);
        exp_blk = '0;
        for (int i = 0; i < 16; i++) exp_blk[64*i +: 64] = 64'h100 + 64'(i);
        exp_blk[64*16 +: 64] = 64'h9F22_3344_5566_7788;
        check_blk("s256");
        check("s256_last", 64'(cap_last), 64'd1);
        check("s256_lanes", 64'(cap_lanes), 64'd17);

        // SHA3-256, 3-byte message, held under backpressure for 10 cycles
        mode = 2'd2;
        send(64'hFFFF_FFFF_FFAB_CDEF, 1'b1, 4'd3);
        get_block(10);
        exp_blk = '0; exp_blk[0 +: 64] = 64'h0000_0000_06AB_CDEF; exp_blk[64*16 +: 64] = TOP80;
        check_blk("sha3_256");
        check("sha3_256_last", 64'(cap_last), 64'd1);
        check("sha3_256_lanes", 64'(cap_lanes), 64'd17);

        // Mode change mid-message must not alter the latched SHAKE128 rate
        mode = 2'd0;
        send(64'hAAAA_0000_0000_0001, 1'b0, 4'd0);
        mode = 2'd3;
        send(64'hBBBB_0000_0000_0002, 1'b1, 4'd8);
        get_block(0);
        check("modechg_latency", 64'(cap_wait), 64'd1);
        exp_blk = '0;
        exp_blk[0 +: 64] = 64'hAAAA_0000_0000_0001;
        exp_blk[64 +: 64] = 64'hBBBB_0000_0000_0002;
        exp_blk[128 +: 64] = 64'h1F;
        exp_blk[64*20 +: 64] = TOP80;
        check_blk("modechg");
        check("modechg_lanes", 64'(cap_lanes), 64'd21);

        // Async reset during cnt=5 of a SHAKE128 message
        mode = 2'd0;
        for (int i = 0; i < 5; i++) send(64'hC0DE_0000 + 64'(i), 1'b0, 4'd0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_last", 64'(out_last), 64'd0);
        check("midrst_out_lanes", 64'(out_lanes), 64'd21);
        check("midrst_block_zero", 64'(out_block === '0), 64'd1);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        mode = 2'd3;
        send(64'h0000_0000_0000_005A, 1'b1, 4'd1);
        get_block(0);
        exp_blk = '0; exp_blk[0 +: 64] = 64'h065A; exp_blk[64*8 +: 64] = TOP80;
        check_blk("postrst");
        check("postrst_last", 64'(cap_last), 64'd1);
        check("postrst_lanes", 64'(cap_lanes), 64'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keccak_padder_multi.md
# keccak_padder_multi

Parametrised successor to the Dilithium absorb-side padder. It accepts a byte-granular message stream as 64-bit little-endian words and assembles rate-sized blocks for the f_permutation core. It applies FIPS 202 multi-rate padding for four selectable modes: SHAKE128, SHAKE256, SHA3-256 and SHA3-512. It handles the full-last-word case by emitting an extra pad-only block, and exposes valid/ready handshakes on both sides.

## Interface
- LANE_W, 64, word/lane width in bits (only 64 supported; parameter kept for lint/generics)
- MAX_LANES, 21, buffer depth in lanes; out_block width = LANE_W*MAX_LANES
- DS_SHAKE, 8'h1F, domain-separation byte for modes 0/1
- DS_SHA3, 8'h06, domain-separation byte for modes 2/3

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mode  in  2  0 SHAKE128 (21 lanes), 1 SHAKE256 (17), 2 SHA3-256 (17), 3 SHA3-512 (9); sampled on first word of a message
- in_data  in  64  message word; byte k = bits [8k+7:8k]
- in_valid  in  1  in_data valid
- in_last  in  1  final word of message
- in_nbytes  in  4  valid bytes in last word, 0..8 (ignored unless in_last); 0 = empty tail word
- in_ready  out  1  padder accepts a word this cycle
- out_block  out  LANE_W*MAX_LANES  lane j at bits [64j+63:64j]; lanes ≥ rate are 0
- out_valid  out  1  block complete
- out_last  out  1  block is the final (padded) block of the message
- out_lanes  out  5  rate in lanes of the latched mode
- out_ready  in  1  permutation consumes block

## Operation
- State: ABSORB, PAD, OUT; word counter cnt (0..rate-1); flags msg_active, pad_pending, last_blk; latched mode.
- ABSORB: in_ready=1. On accept, if !msg_active, latch mode and set msg_active.
  - Non-last word: write lane cnt. If cnt==rate-1, go to OUT with last_blk=0; else cnt++.
  - Last word, in_nbytes<8: write bytes [0..n-1] of lane cnt, byte n = DS, upper bytes 0.
    - If cnt==rate-1, also OR 0x80 into byte 7 of lane cnt, then go to OUT with last_blk=1.
    - Else cnt++, then go to PAD with pad_pending=0.
  - Last word, in_nbytes==8: write full lane.
    - If cnt==rate-1, go to OUT with last_blk=0 and pad_pending=1 (pad-only block follows).
    - Else cnt++, then go to PAD with pad_pending=1.
- PAD (one cycle): OR DS into byte 0 of lane cnt if pad_pending. OR 0x80 into byte 7 of lane rate-1. Clear pad_pending, set last_blk=1, go to OUT.
- OUT: out_valid=1, in_ready=0, buffer frozen.
  - On out_valid&out_ready: clear buffer to 0 and set cnt=0.
  - If pad_pending, go to PAD (cnt=0).
  - Else if last_blk, clear msg_active and go to ABSORB.
  - Else go to ABSORB to continue the message.
- DS and 0x80 in the same byte (n=7 in lane rate-1) yield DS|0x80 (e.g. 0x9F).
- A mode change while msg_active is ignored until the next message.

## Timing
- Reset (reset_n low, async): state=ABSORB, cnt=0, buffer=0, all flags 0, latched mode=0. Outputs: out_valid=0, out_last=0, out_block=0, out_lanes=21, in_ready=1.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid/out_ready.
- Latency from accepting the word that completes a block to out_valid:
  - 1 cycle when the block is completed in ABSORB.
  - 2 cycles when it is completed via PAD.
- out_block, out_last and out_lanes are stable while out_valid=1 and out_ready=0.
- Throughput: one word per cycle in ABSORB. Each block costs rate + 1 cycles minimum, plus handshake stall.
- Reset asserted mid-block or mid-OUT: the partial block is discarded with no output.

## Test plan
- SHAKE128 empty message: in_last=1, in_nbytes=0 at cnt 0 → one block with lane0=0x1F, lane20=0x8000000000000000, others 0; out_last=1, out_lanes=21.
- SHA3-512, 9 full words (0x01..0x09), last with nbytes=8:
  - Block 1: lanes 0..8 = data, out_last=0.
  - Block 2: lane0=0x06, lane8=0x8000000000000000, out_last=1.
- SHAKE256, 17 words, last word 0x1122334455667788 with nbytes=7 → lane16 = 0x9F22334455667788, out_last=1.
- SHA3-256, 3-byte message 0xABCDEF → lane0 = 0x0000000006ABCDEF, lane16 = 0x8000000000000000.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid held, out_block stable, in_ready=0. Change mode mid-message → latched rate unchanged.
- Assert reset_n low during cnt=5 of SHAKE128 → outputs return to reset values immediately. A new message afterwards pads correctly.
